ldm_mem_seq: RTL

Memory-side sequencer for ARMv4 block transfers (LDM/STM), directly downstream of `ldm_ctrl`. It accepts one transfer beat per cycle from `ldm_ctrl`: a valid strobe, a signed offset, a register code and a load/store flag. Each beat is buffered in a 2-entry FIFO. The block then:
- issues word-aligned requests on a req/ack data-memory bus,
- writes loaded words into the register file,
- reads store data from the register file,
- performs base-register writeback after the final beat,
- raises a PC-load pulse when R15 is loaded.

---
 rtl/ldm_mem_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ldm_mem_seq.sv
// Memory-side sequencer for LDM/STM: buffers beats from ldm_ctrl in a 2-entry FIFO,
// issues req/ack memory transfers, writes loaded words and performs base writeback.
module ldm_mem_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        i_base_vld,
    input  logic [31:0] i_base,
    input  logic [3:0]  i_base_code,
    input  logic        i_wb,
    input  logic [31:0] i_wb_offset,
    input  logic        i_ldm_mem_vld,
    input  logic [31:0] i_ldm_offset,
    input  logic [3:0]  i_ldm_reg_code,
    input  logic        i_ldm_l,
    input  logic        i_ldm_last,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_rd_code,
    input  logic [31:0] i_rd_data,
    output logic        o_wr_en,
    output logic [3:0]  o_wr_code,
    output logic [31:0] o_wr_data,
    output logic        o_pc_load,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] base_r;
    logic [3:0]  base_code_r;
    logic        wb_r;
    logic [31:0] wb_off_r;
    logic        base_loaded;

    logic [31:0] fifo_addr [2];
    logic [3:0]  fifo_code [2];
    logic        fifo_l    [2];
    logic        fifo_last [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_nxt;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [31:0] base_eff;
    logic [31:0] push_addr;

    logic [31:0] head_addr;
    logic [3:0]  head_code;
    logic        head_l;
    logic        head_last;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign push      = i_ldm_mem_vld & en & ~full;
    assign pop       = (state == S_REQ) & i_mem_ack;
    // A base context arriving with the beat takes precedence over the latched one.
    assign base_eff  = i_base_vld ? i_base : base_r;
    assign push_addr = base_eff + i_ldm_offset;

    assign head_addr = fifo_addr[rd_ptr];
    assign head_code = fifo_code[rd_ptr];
    assign head_l    = fifo_l[rd_ptr];
    assign head_last = fifo_last[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r      <= '0;
            base_code_r <= '0;
            wb_r        <= 1'b0;
            wb_off_r    <= '0;
        end else if (i_base_vld) begin
            base_r      <= i_base;
            base_code_r <= i_base_code;
            wb_r        <= i_wb;
            wb_off_r    <= i_wb_offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_loaded <= 1'b0;
        end else if (i_base_vld) begin
            base_loaded <= 1'b0;
        end else if (pop && head_l && (head_code == base_code_r)) begin
            base_loaded <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_addr[i] <= '0;
                fifo_code[i] <= '0;
                fifo_l[i]    <= 1'b0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= push_addr;
                fifo_code[wr_ptr] <= i_ldm_reg_code;
                fifo_l[wr_ptr]    <= i_ldm_l;
                fifo_last[wr_ptr] <= i_ldm_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!empty && en) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_ack) begin
                    if (head_last && wb_r) begin
                        state_nxt = S_WB;
                    end else if ((count_nxt != 2'd0) && en) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_WB: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_rd_code   = '0;
        if (state == S_REQ) begin
            o_mem_req   = 1'b1;
            o_mem_addr  = {head_addr[31:2], 2'b00};
            o_mem_we    = ~head_l;
            o_rd_code   = head_code;
            o_mem_wdata = i_rd_data;
        end
    end

    // Load writes follow their ack by one cycle; the WB write is issued from the WB
    // state, which is itself a cycle after the final ack, so the two never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wr_en   <= 1'b0;
            o_wr_code <= '0;
            o_wr_data <= '0;
            o_pc_load <= 1'b0;
        end else begin
            o_wr_en   <= 1'b0;
            o_wr_code <= '0;
            o_wr_data <= '0;
            o_pc_load <= 1'b0;
            if (pop && head_l) begin
                o_wr_en   <= 1'b1;
                o_wr_code <= head_code;
                o_wr_data <= i_mem_rdata;
                o_pc_load <= (head_code == 4'd15);
            end else if ((state == S_WB) && !base_loaded) begin
                o_wr_en   <= 1'b1;
                o_wr_code <= base_code_r;
                o_wr_data <= base_r + wb_off_r;
            end
        end
    end

    assign o_stall = full;
    assign o_busy  = ~empty | (state != S_IDLE) | o_wr_en;

endmodule
